// File: rtl/pipelined_adder_pkg.sv
// Shared definitions for the pipelined adder.
//   OP_ADD / OP_SUB : encoding of the Sub input (0 = A+B, 1 = A-B)
//   DEFAULT_WIDTH   : default operand/result width in bits
//   DEFAULT_STAGES  : default number of pipeline slices
package pipelined_adder_pkg;

  localparam int DEFAULT_WIDTH  = 32;
  localparam int DEFAULT_STAGES = 4;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

endpackage : pipelined_adder_pkg

// File: rtl/pipelined_adder_slice.sv
// adder_slice: one SW-bit ripple slice of the pipelined adder.
//   a, b    : slice operands (b already inverted for subtraction)
//   cin     : carry into bit 0 of the slice
//   sum     : slice sum
//   cout    : carry out of the slice MSB
//   msb_cin : carry into the slice MSB (used for signed overflow)
module adder_slice #(
  parameter int SW = 8
) (
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic          cin,
  output logic [SW-1:0] sum,
  output logic          cout,
  output logic          msb_cin
);

  logic [SW:0] total;

  assign total   = {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, cin};
  assign sum     = total[SW-1:0];
  assign cout    = total[SW];
  // The MSB sum bit is a ^ b ^ carry-in, so the carry-in can be recovered.
  assign msb_cin = a[SW-1] ^ b[SW-1] ^ sum[SW-1];

endmodule : adder_slice

// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit add/subtract split into STAGES carry-registered
// slices with a valid/ready handshake on both sides.
//   Clk, Reset           : clock, synchronous active-high reset
//   in_valid / in_ready  : input beat handshake
//   InputA, InputB, Sub  : operands and operation (0 = A+B, 1 = A-B)
//   out_valid / out_ready: result beat handshake
//   AddResult            : sum or difference modulo 2^WIDTH
//   CarryOut             : carry out of MSB (for Sub, 1 means no borrow)
//   Overflow             : signed two's-complement overflow
//   Zero                 : AddResult equals 0 (only while out_valid)
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] InputA,
  input  logic [WIDTH-1:0] InputB,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] AddResult,
  output logic             CarryOut,
  output logic             Overflow,
  output logic             Zero
);

  localparam int SW   = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_param_check
    $error("pipelined_adder: WIDTH must be a multiple of STAGES, STAGES >= 1");
  end

  // Per-stage registers: operands travel with the beat so later slices
  // always see the operand bits that belong to their own beat.
  logic [STAGES-1:0] valid_q, valid_d;
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  a_d   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic [WIDTH-1:0]  b_d   [STAGES];
  logic [WIDTH-1:0]  res_q [STAGES];
  logic [WIDTH-1:0]  res_d [STAGES];
  logic              carry_q [STAGES];
  logic              carry_d [STAGES];
  logic              ovf_q   [STAGES];
  logic              ovf_d   [STAGES];

  logic [STAGES-1:0] advance;
  logic [WIDTH-1:0]  b_in;

  logic [SW-1:0] slice_a   [STAGES];
  logic [SW-1:0] slice_b   [STAGES];
  logic          slice_cin [STAGES];
  logic [SW-1:0] slice_sum [STAGES];
  logic          slice_cout    [STAGES];
  logic          slice_msb_cin [STAGES];

  // Subtraction is A + ~B + 1: invert B here, the +1 enters as stage-0 cin.
  assign b_in = InputB ^ {WIDTH{Sub == OP_SUB}};

  // A stage may take a new beat when it is empty or its occupant moves on.
  always_comb begin
    advance       = '0;
    advance[LAST] = !valid_q[LAST] || out_ready;
    for (int k = LAST - 1; k >= 0; k--) begin
      advance[k] = !valid_q[k] || advance[k+1];
    end
  end

  assign in_ready = advance[0];

  always_comb begin
    slice_a[0]   = InputA[SW-1:0];
    slice_b[0]   = b_in[SW-1:0];
    slice_cin[0] = Sub;
    for (int k = 1; k < STAGES; k++) begin
      slice_a[k]   = a_q[k-1][k*SW +: SW];
      slice_b[k]   = b_q[k-1][k*SW +: SW];
      slice_cin[k] = carry_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    adder_slice #(.SW(SW)) u_slice (
      .a       (slice_a[k]),
      .b       (slice_b[k]),
      .cin     (slice_cin[k]),
      .sum     (slice_sum[k]),
      .cout    (slice_cout[k]),
      .msb_cin (slice_msb_cin[k])
    );
  end

  always_comb begin
    // NOTE: every output of this block gets a default (hold) first, so no
    // path through the conditionals below can infer a latch.
    valid_d = valid_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;

    // Data only loads when a real beat enters, so a stalled or emptied stage
    // keeps its last contents untouched.
    if (advance[0]) begin
      valid_d[0] = in_valid;
      if (in_valid) begin
        a_d[0]            = InputA;
        b_d[0]            = b_in;
        res_d[0]          = '0;
        res_d[0][SW-1:0]  = slice_sum[0];
        carry_d[0]        = slice_cout[0];
        ovf_d[0]          = slice_msb_cin[0] ^ slice_cout[0];
      end
    end

    for (int k = 1; k < STAGES; k++) begin
      if (advance[k]) begin
        valid_d[k] = valid_q[k-1];
        if (valid_q[k-1]) begin
          a_d[k]               = a_q[k-1];
          b_d[k]               = b_q[k-1];
          res_d[k]             = res_q[k-1];
          res_d[k][k*SW +: SW] = slice_sum[k];
          carry_d[k]           = slice_cout[k];
          ovf_d[k]             = slice_msb_cin[k] ^ slice_cout[k];
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only. The data
  // arrays are reset too, because the outputs must read 0 after reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      valid_q <= '0;
      a_q     <= '{default: '0};
      b_q     <= '{default: '0};
      res_q   <= '{default: '0};
      carry_q <= '{default: 1'b0};
      ovf_q   <= '{default: 1'b0};
    end else begin
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_valid = valid_q[LAST];
  assign AddResult = res_q[LAST];
  assign CarryOut  = carry_q[LAST];
  assign Overflow  = ovf_q[LAST];
  // Zero comes from the final registered result, qualified by valid so it
  // reads 0 after reset.
  assign Zero      = valid_q[LAST] && (res_q[LAST] == '0);

endmodule : pipelined_adder
